// File: rtl/rf_pkg.sv
// Shared types and sizes for the 2R1W general-purpose register file.
// Optional write-through forwarding is enabled by defining RF_BYPASS_EN.
package rf_pkg;

    localparam int RF_WIDTH = 32;
    localparam int RF_NREG  = 32;
    localparam int RF_AW    = 5;

    typedef logic [RF_AW-1:0]    rf_addr_t;
    typedef logic [RF_WIDTH-1:0] rf_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: address decode, x0 zeroing and,
// when RF_BYPASS_EN is defined, same-cycle forwarding of write data.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int NREG  = RF_NREG
) (
    input  logic                        reset,
    input  logic                        w,
    input  rf_addr_t                    wn,
    input  logic [WIDTH-1:0]            wd,
    input  logic [NREG-1:0][WIDTH-1:0]  regs,
    input  rf_addr_t                    addr,
    output logic [WIDTH-1:0]            data
);

    logic [WIDTH-1:0] stored;
    logic             in_range;

    assign in_range = (32'(addr) < NREG);

    // Out-of-range addresses match no entry and fall through to zero
    always_comb begin
        stored = '0;
        for (int i = 0; i < NREG; i++) begin
            if (32'(addr) == i) begin
                stored = regs[i];
            end
        end
    end

`ifdef RF_BYPASS_EN
    logic hit;

    assign hit = !reset && w && (wn != '0) && (wn == addr) && in_range;

    always_comb begin
        data = '0;
        if (addr != '0 && in_range) begin
            data = hit ? wd : stored;
        end
    end
`else
    logic unused_bypass;

    assign unused_bypass = ^{reset, w, wn, wd};

    always_comb begin
        data = '0;
        if (addr != '0 && in_range) begin
            data = stored;
        end
    end
`endif

endmodule

// File: rtl/rf.sv
// 32x32 register file, two combinational reads, one synchronous write.
// Define RF_BYPASS_EN to forward same-cycle write data to the read ports.
module rf
    import rf_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int NREG  = RF_NREG
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  rf_addr_t         rs1,
    input  rf_addr_t         rs2,
    input  rf_addr_t         wn,
    input  logic [WIDTH-1:0] wd,
    input  logic             w
);

    logic [NREG-1:0][WIDTH-1:0] regs;

    // Entry 0 is cleared by reset and never written, so x0 stays zero
    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '0;
        end else if (w) begin
            for (int i = 1; i < NREG; i++) begin
                if (32'(wn) == i) begin
                    regs[i] <= wd;
                end
            end
        end
    end

    rf_read_port #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_port1 (
        .reset (reset),
        .w     (w),
        .wn    (wn),
        .wd    (wd),
        .regs  (regs),
        .addr  (rs1),
        .data  (rd1)
    );

    rf_read_port #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_port2 (
        .reset (reset),
        .w     (w),
        .wn    (wn),
        .wd    (wd),
        .regs  (regs),
        .addr  (rs2),
        .data  (rd2)
    );

endmodule

// File: tb/tb_rf.sv
// Self-checking bench for rf: vector table, directed corner cases and
// randomized traffic against an array model of the register contents.
module tb_rf;

    logic        clk;
    logic        reset;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  wn;
    logic [31:0] wd;
    logic        w;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [5];

    rf dut (
        .clk   (clk),
        .reset (reset),
        .rd1   (rd1),
        .rd2   (rd2),
        .rs1   (rs1),
        .rs2   (rs2),
        .wn    (wn),
        .wd    (wd),
        .w     (w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    function automatic logic [31:0] ref_pre(input logic [4:0] a);
`ifdef RF_BYPASS_EN
        if (!reset && w && wn != 5'd0 && wn == a) return wd;
`endif
        return ref_rd(a);
    endfunction

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (w && wn != 5'd0) begin
            model[wn] = wd;
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            chk({name, "_rd1"}, rd1, 32'd0);
            chk({name, "_rd2"}, rd2, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] e;

        vecs[0] = '{5'd5,  5'd31, 32'd25, 32'd961};
        vecs[1] = '{5'd0,  5'd0,  32'd0,  32'd0};
        vecs[2] = '{5'd7,  5'd12, 32'd49, 32'd144};
        vecs[3] = '{5'd1,  5'd30, 32'd1,  32'd900};
        vecs[4] = '{5'd16, 5'd16, 32'd256, 32'd256};

        reset = 1'b1;
        w     = 1'b0;
        wn    = '0;
        wd    = '0;
        rs1   = '0;
        rs2   = '0;
        tick();
        model_edge();
        reset = 1'b0;
        check_all_zero("reset");

        for (int i = 0; i < 32; i++) begin
            w  = 1'b1;
            wn = 5'(i);
            wd = 32'(i * i);
            tick();
            model_edge();
        end
        w = 1'b0;

        for (int k = 0; k < 5; k++) begin
            rs1 = vecs[k].rs1;
            rs2 = vecs[k].rs2;
            #1;
            chk($sformatf("vec%0d_rd1", k), rd1, vecs[k].e1);
            chk($sformatf("vec%0d_rd2", k), rd2, vecs[k].e2);
        end

        for (int k = 0; k < 10; k++) begin
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            #1;
            chk("sq_rd1", rd1, 32'(int'(rs1) * int'(rs1)));
            chk("sq_rd2", rd2, 32'(int'(rs2) * int'(rs2)));
        end

        w  = 1'b0;
        wn = 5'd7;
        wd = 32'hDEADBEEF;
        rs1 = 5'd7;
        for (int k = 0; k < 3; k++) begin
            tick();
            model_edge();
        end
        chk("w0_hold", rd1, 32'd49);

        w  = 1'b1;
        wn = 5'd0;
        wd = 32'hFFFFFFFF;
        rs1 = 5'd0;
        rs2 = 5'd0;
        #1;
        chk("x0_pre_rd1", rd1, 32'd0);
        tick();
        model_edge();
        w = 1'b0;
        #1;
        chk("x0_rd1", rd1, 32'd0);
        chk("x0_rd2", rd2, 32'd0);

        rs1 = 5'd12;
        rs2 = 5'd12;
        w   = 1'b1;
        wn  = 5'd12;
        wd  = 32'd100;
        #1;
`ifdef RF_BYPASS_EN
        e = 32'd100;
`else
        e = 32'd144;
`endif
        chk("rdw_pre_rd1", rd1, e);
        chk("rdw_pre_rd2", rd2, e);
        tick();
        model_edge();
        w = 1'b0;
        #1;
        chk("rdw_post_rd1", rd1, 32'd100);
        chk("rdw_post_rd2", rd2, 32'd100);

        for (int k = 0; k < 60; k++) begin
            w   = 1'($urandom_range(0, 1));
            wn  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            rs1 = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom_range(0, 31));
            #1;
            chk("rnd_pre_rd1", rd1, ref_pre(rs1));
            chk("rnd_pre_rd2", rd2, ref_pre(rs2));
            tick();
            model_edge();
            w = 1'b0;
            #1;
            chk("rnd_post_rd1", rd1, ref_rd(rs1));
            chk("rnd_post_rd2", rd2, ref_rd(rs2));
        end

        reset = 1'b1;
        w     = 1'b1;
        wn    = 5'd3;
        wd    = 32'd55;
        rs1   = 5'd3;
        rs2   = 5'd3;
        #1;
        chk("rst_pre_rd1", rd1, ref_pre(5'd3));
        tick();
        model_edge();
        reset = 1'b0;
        w     = 1'b0;
        check_all_zero("rst_wr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
